accel_avg_filter: RTL and testbench
===================================

Name: accel_avg_filter

Overview:
- Downstream consumer of the ADXL362 SPI reader's outputs (ax_o/ay_o/az_o/ready_o).
- Keeps a per-axis boxcar moving average over the last 2^p_log2depth samples and presents filtered X/Y/Z with a one-cycle valid strobe.
- Output feeds tilt/display/UART logic that needs noise-reduced acceleration at the same sample rate.

Parameters:
- p_width, 16, sample width; two's-complement signed
- p_log2depth, 3, log2 of the window depth (depth = 8); legal range 1..6

Ports:
- clk_i  in  1  system clock, 100 MHz
- rst_i  in  1  reset, synchronous, active-high
- ax_i  in  p_width  signed X sample from the reader
- ay_i  in  p_width  signed Y sample
- az_i  in  p_width  signed Z sample
- ready_i  in  1  reader data-ready; rising edge marks a new X/Y/Z triplet; pulse or level both legal
- clear_i  in  1  synchronous datapath clear (same effect as rst_i)
- avg_x_o  out  p_width  signed averaged X
- avg_y_o  out  p_width  signed averaged Y
- avg_z_o  out  p_width  signed averaged Z
- valid_o  out  1  one-cycle strobe; averages updated this cycle
- filled_o  out  1  high once 2^p_log2depth samples have been accumulated since the last reset/clear
- overrun_o  out  1  sticky; a ready_i edge arrived while busy

Behaviour:
- Reset/clear: all outputs 0. Every sample buffer entry is 0, every running sum is 0, the write pointer is 0, the fill count is 0, and the FSM is in S_IDLE.
  - Reset or clear mid-operation aborts any in-flight update; nothing is written.
- Edge detect: ready_q is a registered copy of ready_i. A new event is ready_i=1 and ready_q=0 at a clock edge.
- FSM:
  - S_IDLE: on a new event, latch ax_i/ay_i/az_i into capture registers and go to S_UPDATE.
  - S_UPDATE: per axis, sum <= sum + sample - buf[wr_ptr] and buf[wr_ptr] <= sample. wr_ptr increments modulo depth, wrapping from depth-1 to 0. The fill count increments, saturating at depth. Go to S_OUT.
  - S_OUT: avg_*_o <= sum >>> p_log2depth; valid_o <= 1 for one cycle; go to S_IDLE.
- Latency: valid_o and the new averages appear 3 clock edges after the edge where the event is detected.
  - Averages hold until the next S_OUT.
  - The minimum event spacing is 3 cycles.
- Arithmetic:
  - Running sums are p_width+p_log2depth bits, signed, and never overflow.
  - Division is an arithmetic right shift, i.e. floor toward -infinity; no rounding.
  - The result always fits p_width.
- Pre-fill: the buffer starts at zero, so the first depth-1 outputs average in zeros. Consumers gate on filled_o.
- filled_o: goes high in the same cycle as the valid_o that carries the depth-th sample. It stays high until reset or clear.
- Overrun: a new event detected while the FSM is in S_UPDATE or S_OUT is dropped and sets overrun_o. overrun_o clears only on rst_i or clear_i.
- Simultaneous events:
  - clear_i and an event in the same cycle: clear wins and the sample is dropped.
  - rst_i has priority over everything.
  - ready_i held high produces exactly one event.

Test Plan:
- Fill: after reset, 8 events with X=Y=Z=0x0100 spaced 100 cycles apart → avg_x_o steps through 0x0020, 0x0040, … 0x0100. filled_o rises with the 8th valid_o. There are exactly 8 valid_o pulses, each 3 edges after its event.
- Negative floor: after reset, one event with X=0xFFF8 (-8), Y=0xFFFF (-1), Z=0x0007 → avg_x_o=0xFFFF, avg_y_o=0xFFFF, avg_z_o=0x0000.
- Wrap-around: 8 samples of 0x0080, then a 9th of 0x0880 → average becomes 0x0180. Sum and pointer wrap correctly, and filled_o stays 1.
- Extremes: 8× 0x7FFF → 0x7FFF. After clear_i, 8× 0x8000 → 0x8000. No overflow on any axis.
- Overrun: two ready_i rising edges 2 cycles apart → one valid_o, overrun_o=1 and sticky. clear_i → overrun_o=0 and all outputs 0.
- Reset mid-update: assert rst_i in the S_UPDATE cycle → no valid_o and all outputs 0. The next event of 0x0100 yields 0x0020, proving the buffer was zeroed.

Source files
------------

// File: rtl/accel_avg_filter.sv
// Per-axis boxcar moving average over the last 2^p_log2depth accelerometer samples.
// A ready_i rising edge starts a capture -> update -> output sequence; valid_o strobes with the new averages.
module accel_avg_filter #(
  parameter int p_width     = 16,
  parameter int p_log2depth = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [p_width-1:0] ax_i,
  input  logic [p_width-1:0] ay_i,
  input  logic [p_width-1:0] az_i,
  input  logic               ready_i,
  input  logic               clear_i,
  output logic [p_width-1:0] avg_x_o,
  output logic [p_width-1:0] avg_y_o,
  output logic [p_width-1:0] avg_z_o,
  output logic               valid_o,
  output logic               filled_o,
  output logic               overrun_o
);

  localparam int DEPTH = 1 << p_log2depth;
  localparam int SW    = p_width + p_log2depth;
  localparam int CW    = p_log2depth + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_OUT} state_t;

  state_t                              state_q, state_d;
  logic                                ready_q, ready_d;
  logic                                evt_q, evt_d;
  logic [2:0][p_width-1:0]             cap_q, cap_d;
  logic [DEPTH-1:0][2:0][p_width-1:0]  buf_q, buf_d;
  logic [2:0][SW-1:0]                  sum_q, sum_d;
  logic [p_log2depth-1:0]              wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [2:0][p_width-1:0]             avg_q, avg_d;
  logic                                valid_q, valid_d;
  logic                                filled_q, filled_d;
  logic                                overrun_q, overrun_d;
  logic signed [SW-1:0]                shifted;

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_i;
    // Event is registered so the FSM acts one edge after detection.
    evt_d     = ready_i & ~ready_q;
    cap_d     = evt_d ? {az_i, ay_i, ax_i} : cap_q;
    buf_d     = buf_q;
    sum_d     = sum_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    valid_d   = 1'b0;
    filled_d  = filled_q;
    overrun_d = overrun_q | (evt_q & (state_q != S_IDLE));
    shifted   = '0;

    case (state_q)
      S_IDLE: begin
        if (evt_q) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        for (int a = 0; a < 3; a++) begin
          buf_d[wr_ptr_q][a] = cap_q[a];
          sum_d[a] = sum_q[a]
                   + {{p_log2depth{cap_q[a][p_width-1]}}, cap_q[a]}
                   - {{p_log2depth{buf_q[wr_ptr_q][a][p_width-1]}}, buf_q[wr_ptr_q][a]};
        end
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        for (int a = 0; a < 3; a++) begin
          shifted  = $signed(sum_q[a]) >>> p_log2depth;
          avg_d[a] = shifted[p_width-1:0];
        end
        valid_d  = 1'b1;
        filled_d = filled_q | (cnt_q == DEPTH_C);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear behaves like reset; ready_q tracks ready_i so a held level does not re-fire.
    if (clear_i) begin
      state_d   = S_IDLE;
      evt_d     = 1'b0;
      cap_d     = '0;
      buf_d     = '0;
      sum_d     = '0;
      wr_ptr_d  = '0;
      cnt_d     = '0;
      avg_d     = '0;
      valid_d   = 1'b0;
      filled_d  = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ready_q   <= ready_i;
      evt_q     <= 1'b0;
      cap_q     <= '0;
      buf_q     <= '0;
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      valid_q   <= 1'b0;
      filled_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      evt_q     <= evt_d;
      cap_q     <= cap_d;
      buf_q     <= buf_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      valid_q   <= valid_d;
      filled_q  <= filled_d;
      overrun_q <= overrun_d;
    end
  end

  assign avg_x_o   = avg_q[0];
  assign avg_y_o   = avg_q[1];
  assign avg_z_o   = avg_q[2];
  assign valid_o   = valid_q;
  assign filled_o  = filled_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_accel_avg_filter.sv
// Directed bench for accel_avg_filter: table of sample events with hand-derived averages
// plus hand-written sequences for overrun, held ready, clear collisions and reset mid-update.
module tb_accel_avg_filter;

  logic        clk = 1'b0;
  logic        rst, ready, clear;
  logic [15:0] ax, ay, az;
  logic [15:0] avg_x, avg_y, avg_z;
  logic        valid, filled, overrun;

  always #5 clk = ~clk;

  accel_avg_filter #(.p_width(16), .p_log2depth(3)) dut (
    .clk_i(clk), .rst_i(rst), .ax_i(ax), .ay_i(ay), .az_i(az),
    .ready_i(ready), .clear_i(clear),
    .avg_x_o(avg_x), .avg_y_o(avg_y), .avg_z_o(avg_z),
    .valid_o(valid), .filled_o(filled), .overrun_o(overrun)
  );

  typedef struct {
    logic        clr;
    logic [15:0] x, y, z;
    logic [15:0] ex, ey, ez;
    logic        ef;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0, errors = 0;
  int   vcount = 0, exp_v = 0;

  always @(negedge clk) if (valid) vcount++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avg_x"}, 32'(avg_x), 32'h0);
    chk({tag, "_avg_y"}, 32'(avg_y), 32'h0);
    chk({tag, "_avg_z"}, 32'(avg_z), 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_filled"}, 32'(filled), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    chk_zero("clear");
  endtask

  // One event; valid must be low 2 edges after detection, high after the 3rd, low again after the 4th.
  task automatic send(input logic [15:0] x, y, z, ex, ey, ez, input logic ef);
    ax = x; ay = y; az = z;
    ready = 1'b1; tick();
    ready = 1'b0; tick(); tick();
    chk("lat_early", 32'(valid), 32'h0);
    tick();
    chk("lat_valid", 32'(valid), 32'h1);
    chk("avg_x", 32'(avg_x), 32'(ex));
    chk("avg_y", 32'(avg_y), 32'(ey));
    chk("avg_z", 32'(avg_z), 32'(ez));
    chk("filled", 32'(filled), 32'(ef));
    exp_v++;
    tick();
    chk("valid_pulse", 32'(valid), 32'h0);
    chk("avg_hold", 32'(avg_x), 32'(ex));
    repeat (4) tick();
  endtask

  function automatic vec_t mk(logic clr, logic [15:0] x, y, z, ex, ey, ez, logic ef);
    vec_t v;
    v.clr = clr; v.x = x; v.y = y; v.z = z;
    v.ex = ex; v.ey = ey; v.ez = ez; v.ef = ef;
    return v;
  endfunction

  initial begin
    int v0;
    rst = 1'b1; ready = 1'b0; clear = 1'b0; ax = '0; ay = '0; az = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Fill: X=0x100, Y=0x200, Z=-0x100 -> averages step by 0x20, 0x40, -0x20.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b0, 16'h0100, 16'h0200, 16'hFF00,
                        16'(k * 32), 16'(k * 64), 16'(-(k * 32)), k == 8));
    // Negative floor toward -infinity.
    vecs.push_back(mk(1'b1, 16'hFFF8, 16'hFFFF, 16'h0007, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0));
    // Wrap-around: eight 0x80 then 0x880 replaces the oldest -> 0xC00/8 = 0x180.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(k == 1, 16'h0080, 16'h0080, 16'h0080,
                        16'(k * 16), 16'(k * 16), 16'(k * 16), k == 8));
    vecs.push_back(mk(1'b0, 16'h0880, 16'h0080, 16'h0880, 16'h0180, 16'h0080, 16'h0180, 1'b1));
    // Extremes, positive then negative.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(k == 1, 16'h7FFF, 16'h8000, 16'h0001,
                        16'((k * 32767) / 8), 16'(-4096 * k), (k == 8) ? 16'h0001 : 16'h0000, k == 8));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(k == 1, 16'h8000, 16'h7FFF, 16'hFFFF,
                        16'(-4096 * k), 16'((k * 32767) / 8), 16'hFFFF, k == 8));

    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear();
      send(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ex, vecs[i].ey, vecs[i].ez, vecs[i].ef);
    end

    // Reset during the update cycle: nothing written, buffer of 0x8000 is wiped.
    v0 = vcount;
    ax = 16'h0100; ay = 16'h0100; az = 16'h0100;
    ready = 1'b1; tick();
    ready = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (6) tick();
    chk("rst_mid_no_valid", 32'(vcount - v0), 32'h0);
    chk_zero("rst_mid");
    send(16'h0100, 16'h0100, 16'h0100, 16'h0020, 16'h0020, 16'h0020, 1'b0);

    // Overrun: second rising edge 2 cycles after the first is dropped.
    do_clear();
    v0 = vcount;
    ax = 16'h0100; ay = 16'h0200; az = 16'h0300;
    ready = 1'b1; tick();
    ready = 1'b0; tick();
    ready = 1'b1; tick();
    ready = 1'b0;
    repeat (10) tick();
    exp_v++;
    chk("ovr_one_valid", 32'(vcount - v0), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_avg_z", 32'(avg_z), 32'h0060);
    repeat (5) tick();
    chk("ovr_sticky", 32'(overrun), 32'h1);
    do_clear();

    // Held-high ready gives exactly one event.
    v0 = vcount;
    ax = 16'h0800; ay = 16'h0000; az = 16'h0000;
    ready = 1'b1;
    repeat (20) tick();
    ready = 1'b0;
    repeat (5) tick();
    exp_v++;
    chk("held_one_valid", 32'(vcount - v0), 32'h1);
    chk("held_avg_x", 32'(avg_x), 32'h0100);
    chk("held_no_ovr", 32'(overrun), 32'h0);

    // Clear coincident with an event: clear wins, sample dropped.
    v0 = vcount;
    ax = 16'h4000;
    ready = 1'b1; clear = 1'b1; tick();
    clear = 1'b0;
    repeat (6) tick();
    ready = 1'b0; tick();
    chk("clr_evt_no_valid", 32'(vcount - v0), 32'h0);
    chk("clr_evt_avg_x", 32'(avg_x), 32'h0);

    chk("valid_count", 32'(vcount), 32'(exp_v));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
